// File: rtl/mod_exp_engine.sv
// Square-and-multiply modular exponentiation (base^exp mod modulus), MSB-first,
// with bit-serial shift-add modular multiplies. Define MODEXP_CONST_TIME_EN for fixed latency.
module mod_exp_engine #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     base_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0]     mod_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [WIDTH-1:0]     res_o,
    output logic                 res_err_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_SQUARE, S_MULT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d;   // raw base, then reduced base after REDUCE
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     op_a, op_b;
    logic [WIDTH:0]       t;
    logic                 exp_bit;
    logic                 last_step;

    // One interleaved shift-add step of op_a*op_b mod m; op_b < m keeps t below 2m.
    always_comb begin
        op_a = r_q;
        op_b = r_q;
        if (state_q == S_REDUCE) begin
            op_a = base_q;
            op_b = WIDTH'(1);
        end else if (state_q == S_MULT) begin
            op_b = base_q;
        end
        t = {acc_q, 1'b0};
        if (t >= {1'b0, mod_q}) t = t - {1'b0, mod_q};
        if (op_a[cnt_q])        t = t + {1'b0, op_b};
        if (t >= {1'b0, mod_q}) t = t - {1'b0, mod_q};
    end

    assign exp_bit   = exp_q[k_q];
    assign last_step = (cnt_q == '0);

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
        state_d = state_q;
        base_d  = base_q;
        mod_d   = mod_q;
        r_d     = r_q;
        acc_d   = acc_q;
        res_d   = res_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    base_d = base_i;
                    exp_d  = exp_i;
                    mod_d  = mod_i;
                    acc_d  = '0;
                    cnt_d  = CW'(WIDTH - 1);
                    err_d  = 1'b0;
                    if (mod_i == '0) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (mod_i == WIDTH'(1)) begin
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end
            end

            S_REDUCE, S_SQUARE, S_MULT: begin
                acc_d = t[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    acc_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (state_q == S_REDUCE) begin
                        base_d  = t[WIDTH-1:0];
                        r_d     = WIDTH'(1);
                        k_d     = KW'(EXP_WIDTH - 1);
                        state_d = S_SQUARE;
                    end else if (state_q == S_SQUARE) begin
                        r_d = t[WIDTH-1:0];
`ifdef MODEXP_CONST_TIME_EN
                        state_d = S_MULT;
`else
                        // Zero exponent bits skip the multiply entirely.
                        if (exp_bit) begin
                            state_d = S_MULT;
                        end else if (k_q == '0) begin
                            res_d   = t[WIDTH-1:0];
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q - KW'(1);
                            state_d = S_SQUARE;
                        end
`endif
                    end else begin
                        if (exp_bit) r_d = t[WIDTH-1:0];
                        if (k_q == '0) begin
                            res_d   = exp_bit ? t[WIDTH-1:0] : r_q;
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q - KW'(1);
                            state_d = S_SQUARE;
                        end
                    end
                end
            end

            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            mod_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mod_q   <= mod_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign res_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign res_o       = res_q;
    assign res_err_o   = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine: an 8-bit and a 32-bit instance, hand-computed results,
// latency expectations follow whichever MODEXP_CONST_TIME_EN build is compiled.
module tb_mod_exp_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // 8-bit instance
    logic [7:0] base8 = '0, mod8 = '0, exp8 = '0, res8;
    logic       in_valid8 = 1'b0, res_ready8 = 1'b0;
    logic       in_ready8, err8, res_valid8, busy8;

    // 32-bit instance
    logic [31:0] base32 = '0, mod32 = '0, exp32 = '0, res32;
    logic        in_valid32 = 1'b0, res_ready32 = 1'b0;
    logic        in_ready32, err32, res_valid32, busy32;

    mod_exp_engine #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .base_i(base8), .exp_i(exp8), .mod_i(mod8),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .res_o(res8), .res_err_o(err8),
        .res_valid_o(res_valid8), .res_ready_i(res_ready8), .busy_o(busy8)
    );

    mod_exp_engine #(.WIDTH(32), .EXP_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .base_i(base32), .exp_i(exp32), .mod_i(mod32),
        .in_valid_i(in_valid32), .in_ready_o(in_ready32), .res_o(res32), .res_err_o(err32),
        .res_valid_o(res_valid32), .res_ready_i(res_ready32), .busy_o(busy32)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input int w, input int ew, input logic [31:0] e);
`ifdef MODEXP_CONST_TIME_EN
        return w * (1 + 2 * ew) + 1;
`else
        return w * (1 + ew + $countones(e)) + 1;
`endif
    endfunction

    // Launch one operation on the 8-bit engine; lat counts edges from accept until res_valid is seen.
    task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m, output int lat);
        int guard = 0;
        while (!in_ready8 && guard < 5000) begin step(); guard++; end
        base8 = b; exp8 = e; mod8 = m; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        lat = 1;
        while (!res_valid8 && lat < 5000) begin step(); lat++; end
    endtask

    task automatic run32(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m, output int lat);
        int guard = 0;
        while (!in_ready32 && guard < 5000) begin step(); guard++; end
        base32 = b; exp32 = e; mod32 = m; in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        lat = 1;
        while (!res_valid32 && lat < 5000) begin step(); lat++; end
    endtask

    task automatic ack8();
        res_ready8 = 1'b1;
        step();
        res_ready8 = 1'b0;
    endtask

    task automatic ack32();
        res_ready32 = 1'b1;
        step();
        res_ready32 = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset values while rst is held low
        #12;
        check("rst_in_ready", 64'(in_ready8), 64'd1);
        check("rst_res_valid", 64'(res_valid8), 64'd0);
        check("rst_res", 64'(res8), 64'd0);
        check("rst_err", 64'(err8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        rst = 1'b1;
        step();

        // 3^5 mod 7 = 5
        run8(8'd3, 8'd5, 8'd7, lat);
        check("basic_res", 64'(res8), 64'd5);
        check("basic_err", 64'(err8), 64'd0);
        check("basic_lat", 64'(lat), 64'(exp_latency(8, 8, 32'd5)));
        ack8();

        // 32-bit: 4^13 mod 497 = 445, and an unreduced base 501 gives the same
        run32(32'd4, 32'd13, 32'd497, lat);
        check("w32_res", 64'(res32), 64'd445);
        check("w32_lat", 64'(lat), 64'(exp_latency(32, 32, 32'd13)));
        ack32();
        run32(32'd501, 32'd13, 32'd497, lat);
        check("w32_bigbase_res", 64'(res32), 64'd445);
        check("w32_bigbase_err", 64'(err32), 64'd0);
        ack32();

        // Edge operands
        run8(8'd3, 8'd0, 8'd7, lat);
        check("exp0_res", 64'(res8), 64'd1);
        ack8();
        run8(8'd5, 8'd9, 8'd1, lat);
        check("mod1_res", 64'(res8), 64'd0);
        check("mod1_err", 64'(err8), 64'd0);
        ack8();
        run8(8'd5, 8'd9, 8'd0, lat);
        check("mod0_res", 64'(res8), 64'd0);
        check("mod0_err", 64'(err8), 64'd1);
        check("mod0_lat", 64'(lat), 64'd1);
        ack8();

        // Backpressure: result and in_ready frozen for 20 cycles
        run8(8'd3, 8'd5, 8'd7, lat);
        check("bp_first_res", 64'(res8), 64'd5);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold_res", 64'(res8), 64'd5);
            check("bp_hold_in_ready", 64'(in_ready8), 64'd0);
            check("bp_hold_valid", 64'(res_valid8), 64'd1);
        end
        res_ready8 = 1'b1;
        step();
        res_ready8 = 1'b0;
        check("bp_in_ready_after", 64'(in_ready8), 64'd1);
        check("bp_valid_dropped", 64'(res_valid8), 64'd0);
        check("bp_res_retained", 64'(res8), 64'd5);
        // Back-to-back: 6^7 mod 13 = 7
        run8(8'd6, 8'd7, 8'd13, lat);
        check("b2b_res", 64'(res8), 64'd7);
        ack8();

        // Async reset during SQUARE of 3^5 mod 7
        base8 = 8'd3; exp8 = 8'd5; mod8 = 8'd7; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("pre_rst_busy", 64'(busy8), 64'd1);
        rst = 1'b0;
        #2;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready8), 64'd1);
        check("mid_rst_valid", 64'(res_valid8), 64'd0);
        check("mid_rst_res", 64'(res8), 64'd0);
        check("mid_rst_err", 64'(err8), 64'd0);
        step();
        rst = 1'b1;
        step();
        run8(8'd3, 8'd5, 8'd7, lat);
        check("post_rst_res", 64'(res8), 64'd5);
        ack8();

        // Exponent bit density: 3^128 mod 7 = 2, 3^255 mod 7 = 6
        run8(8'd3, 8'h80, 8'd7, lat);
        check("exp80_res", 64'(res8), 64'd2);
        check("exp80_lat", 64'(lat), 64'(exp_latency(8, 8, 32'h80)));
        ack8();
        run8(8'd3, 8'hFF, 8'd7, lat);
        check("expff_res", 64'(res8), 64'd6);
        check("expff_lat", 64'(lat), 64'(exp_latency(8, 8, 32'hFF)));
        ack8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
